// File: rtl/uart_rx_controller.sv
// UART receive sequencer: 8x oversample tick, start-bit detector hookup, framing and valid/ready delivery.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_controller #(
  parameter int CLKS_PER_SAMPLE = 27,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK,
    S_CLEAR
  } state_t;

  state_t               r_state, w_stateNext;
  logic                 r_sync1, r_rxS;
  logic [CW-1:0]        r_smpCnt;
  logic                 w_tick;
  logic                 r_rstFlag;
  logic                 w_detRst, w_startDet;
  logic [2:0]           r_tickCnt, w_tickCntNext;
  logic [IW-1:0]        r_bitIdx, w_bitIdxNext;
  logic [DATA_BITS-1:0] r_shift, w_shiftNext;
  logic                 w_deliver, w_frameErr;
  logic [DATA_BITS-1:0] r_dataOut;
  logic                 r_dataValid, r_framingErr, r_overrun;
`ifdef UART_RX_PARITY_EN
  logic                 r_parBit, w_parBitNext, w_parErr, r_parErr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_rxS     <= 1'b1;
      r_smpCnt  <= '0;
      r_rstFlag <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_rxS     <= r_sync1;
      r_smpCnt  <= w_tick ? '0 : r_smpCnt + CW'(1);
      r_rstFlag <= 1'b0;
    end
  end

  assign w_tick   = (r_smpCnt == TICK_LAST);
  assign w_detRst = r_rstFlag | (r_state == S_CLEAR);

  start_bit_detector u_det (
    .i_clk                (clk),
    .i_rst                (w_detRst),
    .i_sample_trigger     (w_tick),
    .i_data               (r_rxS),
    .o_start_bit_detected (w_startDet)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tickCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_parBit  <= 1'b0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_tickCnt <= w_tickCntNext;
      r_bitIdx  <= w_bitIdxNext;
      r_shift   <= w_shiftNext;
`ifdef UART_RX_PARITY_EN
      r_parBit  <= w_parBitNext;
`endif
    end
  end

  // The 3-bit tick counter wraps, so after the first capture at count 3 the next one lands 8 ticks later.
  always_comb begin
    w_stateNext   = r_state;
    w_tickCntNext = r_tickCnt;
    w_bitIdxNext  = r_bitIdx;
    w_shiftNext   = r_shift;
    w_deliver     = 1'b0;
    w_frameErr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parBitNext  = r_parBit;
    w_parErr      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_startDet) begin
          w_stateNext   = S_DATA;
          w_tickCntNext = '0;
          w_bitIdxNext  = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_tickCntNext = r_tickCnt + 3'd1;
          if (r_tickCnt == 3'd3) begin
            w_shiftNext  = {r_rxS, r_shift[DATA_BITS-1:1]};
            w_bitIdxNext = r_bitIdx + IW'(1);
            if (r_bitIdx == BIT_LAST) begin
              w_tickCntNext = '0;
`ifdef UART_RX_PARITY_EN
              w_stateNext   = S_PARITY;
`else
              w_stateNext   = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_tickCntNext = r_tickCnt + 3'd1;
          if (r_tickCnt == 3'd7) begin
            w_parBitNext  = r_rxS;
            w_tickCntNext = '0;
            w_stateNext   = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_tickCntNext = r_tickCnt + 3'd1;
          if (r_tickCnt == 3'd7) begin
            if (!r_rxS) begin
              w_frameErr  = 1'b1;
              w_stateNext = S_BREAK;
            end else begin
              w_stateNext = S_CLEAR;
`ifdef UART_RX_PARITY_EN
              if (^{r_shift, r_parBit}) w_parErr = 1'b1;
              else w_deliver = 1'b1;
`else
              w_deliver   = 1'b1;
`endif
            end
          end
        end
      end
      S_BREAK: begin
        if (w_tick && r_rxS) w_stateNext = S_CLEAR;
      end
      S_CLEAR: w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // A new word may replace the held one only when the consumer takes the old one in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataOut    <= '0;
      r_dataValid  <= 1'b0;
      r_framingErr <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parErr     <= 1'b0;
`endif
    end else begin
      r_framingErr <= w_frameErr;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parErr     <= w_parErr;
`endif
      if (w_deliver && (!r_dataValid || data_ready)) begin
        r_dataOut   <= r_shift;
        r_dataValid <= 1'b1;
      end else begin
        if (w_deliver) r_overrun <= 1'b1;
        if (r_dataValid && data_ready) r_dataValid <= 1'b0;
      end
    end
  end

  assign data_out      = r_dataOut;
  assign data_valid    = r_dataValid;
  assign framing_error = r_framingErr;
  assign overrun       = r_overrun;
  assign busy          = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = r_parErr;
`endif

endmodule

// Confirms a start bit after seven consecutive low samples; shorter low pulses are treated as glitches.
module start_bit_detector (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sample_trigger,
  input  logic i_data,
  output logic o_start_bit_detected
);

  localparam logic [2:0] LOW_LAST = 3'd6;

  logic [2:0] r_lowCnt;
  logic       r_det;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lowCnt <= '0;
      r_det    <= 1'b0;
    end else begin
      r_det <= 1'b0;
      if (i_sample_trigger) begin
        if (i_data) begin
          r_lowCnt <= '0;
        end else if (r_lowCnt == LOW_LAST) begin
          r_lowCnt <= '0;
          r_det    <= 1'b1;
        end else begin
          r_lowCnt <= r_lowCnt + 3'd1;
        end
      end
    end
  end

  assign o_start_bit_detected = r_det;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller: directed frames at 4 clk per sample tick (32 clk per bit).
module tb_uart_rx_controller;

  localparam int BIT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady;
  logic       framingError;
  logic       overrunSig;
  logic       busySig;
`ifdef UART_RX_PARITY_EN
  logic       parityError;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] expQ[$];
  int ncyc = 0;
  int lastStartN = 0;
  int lastRiseN = 0;
  int feCnt = 0, ovCnt = 0, busyCnt = 0, bothCnt = 0;
  int validRises = 0, validLen = 0, lastValidLen = 0, accepted = 0;

  uart_rx_controller #(.CLKS_PER_SAMPLE(4), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .data_out      (dataOut),
    .data_valid    (dataValid),
    .data_ready    (dataReady),
    .framing_error (framingError),
    .overrun       (overrunSig),
    .busy          (busySig)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error  (parityError)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task holdBit(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // Sends start + 8 data bits LSB first + stop, then idle bits; must be called at posedge+1.
  task applyStimulus(input logic [7:0] b, input logic stopBit, input int idleBits);
    lastStartN = ncyc;
    holdBit(1'b0);
    for (int i = 0; i < 8; i++) holdBit(b[i]);
    holdBit(stopBit);
    for (int i = 0; i < idleBits; i++) holdBit(1'b1);
  endtask

  // Monitor: pops the scoreboard on every accepted word and tallies pulses.
  initial begin
    logic       prevValid = 1'b0;
    logic       prevReady = 1'b0;
    logic [7:0] prevOut = 8'h00;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevValid = 1'b0;
        prevReady = 1'b0;
        validLen  = 0;
      end else begin
        if (framingError) feCnt++;
        if (overrunSig) ovCnt++;
        if (busySig) busyCnt++;
        if (framingError && overrunSig) bothCnt++;
        if (dataValid && !prevValid) begin
          validRises++;
          lastRiseN = ncyc;
        end
        if (dataValid) validLen++;
        else if (prevValid) begin
          lastValidLen = validLen;
          validLen = 0;
        end
        if (prevValid && !prevReady && dataValid) checkOutput("data_out_hold", dataOut, prevOut);
        if (dataValid && dataReady) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word at %0t", dataOut, $time);
          end else begin
            exp = expQ.pop_front();
            checkOutput("scoreboard_word", dataOut, exp);
            accepted++;
          end
        end
        prevValid = dataValid;
        prevReady = dataReady;
        prevOut   = dataOut;
      end
      ncyc++;
    end
  end

  initial begin
    int fe0, ov0, b0, r0, d;
    rst_n = 1'b0;
    rx = 1'b1;
    dataReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_data_out", dataOut, 0);
    checkOutput("reset_valid", dataValid, 0);
    checkOutput("reset_framing", framingError, 0);
    checkOutput("reset_overrun", overrunSig, 0);
    checkOutput("reset_busy", busySig, 0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] byte delivery 0xA5");
    fe0 = feCnt; ov0 = ovCnt;
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, 2);
    checkOutput("t1_valid_len", lastValidLen, 1);
    checkOutput("t1_framing_cnt", feCnt - fe0, 0);
    checkOutput("t1_overrun_cnt", ovCnt - ov0, 0);
    checkOutput("t1_busy_idle", busySig, 0);
    checkOutput("t1_queue_empty", expQ.size(), 0);

    $display("[TB] glitch rejection");
    b0 = busyCnt; r0 = validRises;
    rx = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    checkOutput("glitch_busy_cycles", busyCnt - b0, 0);
    checkOutput("glitch_valid_rises", validRises - r0, 0);

    $display("[TB] framing error 0x3C then 0x55");
    fe0 = feCnt; r0 = validRises;
    applyStimulus(8'h3C, 1'b0, 0);
    holdBit(1'b0);
    holdBit(1'b0);
    holdBit(1'b1);
    holdBit(1'b1);
    checkOutput("fe_pulse_cnt", feCnt - fe0, 1);
    checkOutput("fe_no_valid", validRises - r0, 0);
    expQ.push_back(8'h55);
    applyStimulus(8'h55, 1'b1, 2);
    checkOutput("fe_next_queue_empty", expQ.size(), 0);

    $display("[TB] overrun 0x11 then 0x22");
    dataReady = 1'b0;
    fe0 = feCnt; ov0 = ovCnt;
    expQ.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 1);
    applyStimulus(8'h22, 1'b1, 2);
    checkOutput("ovr_pulse_cnt", ovCnt - ov0, 1);
    checkOutput("ovr_framing_cnt", feCnt - fe0, 0);
    checkOutput("ovr_data_kept", dataOut, 8'h11);
    checkOutput("ovr_valid_held", dataValid, 1);
    dataReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ovr_valid_drop", dataValid, 0);
    checkOutput("ovr_queue_empty", expQ.size(), 0);

    $display("[TB] accept/load collision");
    dataReady = 1'b0;
    ov0 = ovCnt;
    expQ.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 1);
    d = lastRiseN - lastStartN;
    expQ.push_back(8'h22);
    fork
      applyStimulus(8'h22, 1'b1, 2);
      begin
        repeat (d - 1) @(posedge clk);
        #1;
        dataReady = 1'b1;
        @(posedge clk);
        #1;
        dataReady = 1'b0;
        checkOutput("col_valid_stays", dataValid, 1);
        checkOutput("col_data_new", dataOut, 8'h22);
      end
    join
    checkOutput("col_overrun_cnt", ovCnt - ov0, 0);
    dataReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("col_queue_empty", expQ.size(), 0);

    $display("[TB] reset mid-frame 0xFF then 0x81");
    holdBit(1'b0);
    holdBit(1'b1);
    holdBit(1'b1);
    holdBit(1'b1);
    repeat (16) @(posedge clk);
    #1;
    checkOutput("mid_busy", busySig, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_data_out", dataOut, 0);
    checkOutput("mid_rst_valid", dataValid, 0);
    checkOutput("mid_rst_framing", framingError, 0);
    checkOutput("mid_rst_overrun", overrunSig, 0);
    checkOutput("mid_rst_busy", busySig, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    expQ.push_back(8'h81);
    applyStimulus(8'h81, 1'b1, 2);

    checkOutput("final_queue_empty", expQ.size(), 0);
    checkOutput("final_accepted", accepted, 6);
    checkOutput("final_framing_total", feCnt, 1);
    checkOutput("final_overrun_total", ovCnt, 1);
    checkOutput("final_fe_ov_same_cycle", bothCnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
